// File: rtl/fir_coeff_ctrl.sv
// fir_coeff_ctrl
// Coefficient-bank and input-sequencing controller for the 11-tap myfir filter.
// Holds a shadow coefficient bank written through a small register port,
// forwards the upstream sample stream into the filter, and counts samples in
// flight. A commit request stalls upstream, drains the filter and then copies
// the shadow bank into the live B0..B10 outputs in one cycle, so every filter
// output is computed with a consistent set of taps.
//
// Ports:
//   CLK, RST_n            clock (rising edge), asynchronous active-low reset
//   VIN_UP, DIN_UP        upstream sample valid / data
//   READY_UP              upstream may present a sample
//   VIN, DIN              registered sample valid / data to the FIR
//   VOUT_FIR              FIR retire pulse, one per sample leaving the filter
//   CFG_WE/ADDR/DATA      shadow-bank write port (taps 0..10)
//   CFG_COMMIT            request a shadow-to-live bank swap
//   CFG_BUSY              high while draining or swapping
//   CFG_DONE              one-cycle pulse while the swap happens
//   CFG_ERR               sticky error flag, cleared only by reset
//   B0..B10               live coefficients to the FIR
module fir_coeff_ctrl #(
    parameter int NB            = 8,
    parameter int MAX_INFLIGHT  = 15,
    parameter int CNT_W         = 4,
    parameter int DRAIN_TIMEOUT = 64
) (
    input  logic          CLK,
    input  logic          RST_n,
    input  logic          VIN_UP,
    input  logic [NB-1:0] DIN_UP,
    output logic          READY_UP,
    output logic          VIN,
    output logic [NB-1:0] DIN,
    input  logic          VOUT_FIR,
    input  logic          CFG_WE,
    input  logic [3:0]    CFG_ADDR,
    input  logic [NB-1:0] CFG_DATA,
    input  logic          CFG_COMMIT,
    output logic          CFG_BUSY,
    output logic          CFG_DONE,
    output logic          CFG_ERR,
    output logic [NB-1:0] B0,
    output logic [NB-1:0] B1,
    output logic [NB-1:0] B2,
    output logic [NB-1:0] B3,
    output logic [NB-1:0] B4,
    output logic [NB-1:0] B5,
    output logic [NB-1:0] B6,
    output logic [NB-1:0] B7,
    output logic [NB-1:0] B8,
    output logic [NB-1:0] B9,
    output logic [NB-1:0] B10
);

    localparam int NTAPS = 11;
    localparam int TMR_W = $clog2(DRAIN_TIMEOUT + 1);
    localparam logic [CNT_W:0]   MAX_CNT      = (CNT_W + 1)'(MAX_INFLIGHT);
    localparam logic [TMR_W-1:0] TIMEOUT_LAST = TMR_W'(DRAIN_TIMEOUT - 1);
    localparam logic [3:0]       LAST_ADDR    = 4'(NTAPS - 1);

    typedef enum logic [1:0] {
        IDLE,
        DRAIN,
        SWAP
    } state_t;

    state_t              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [TMR_W-1:0]    timer_q, timer_d;
    logic                vin_q, vin_d;
    logic [NB-1:0]       din_q, din_d;
    logic                err_q, err_d;
    logic [NB-1:0]       shadow_q [NTAPS];
    logic [NB-1:0]       shadow_d [NTAPS];
    logic [NB-1:0]       live_q   [NTAPS];
    logic [NB-1:0]       live_d   [NTAPS];

    logic                accept;
    logic                drain_empty;
    logic [CNT_W:0]      pending;

    // A sample sitting on VIN is not yet in cnt, so it is added in here;
    // otherwise a back-to-back stream would overshoot the limit by one and
    // wrap the counter.
    assign pending     = {1'b0, cnt_q} + {{CNT_W{1'b0}}, vin_q};
    assign READY_UP    = (state_q == IDLE) && (pending < MAX_CNT);
    assign accept      = VIN_UP && READY_UP;
    assign drain_empty = (cnt_q == '0) && !vin_q;

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        timer_d  = '0;
        err_d    = err_q;
        vin_d    = accept;
        din_d    = accept ? DIN_UP : din_q;
        shadow_d = shadow_q;
        live_d   = live_q;

        // In-flight accounting: simultaneous enter and retire cancel out.
        if (vin_q && !VOUT_FIR) begin
            cnt_d = cnt_q + CNT_W'(1);
        end else if (!vin_q && VOUT_FIR) begin
            if (cnt_q == '0) begin
                err_d = 1'b1;
            end else begin
                cnt_d = cnt_q - CNT_W'(1);
            end
        end

        // Shadow writes land only while idle, which includes the commit cycle.
        if (CFG_WE) begin
            if (state_q != IDLE || CFG_ADDR > LAST_ADDR) begin
                err_d = 1'b1;
            end else begin
                for (int i = 0; i < NTAPS; i++) begin
                    if (CFG_ADDR == 4'(i)) begin
                        shadow_d[i] = CFG_DATA;
                    end
                end
            end
        end

        case (state_q)
            IDLE: begin
                if (CFG_COMMIT) begin
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                timer_d = timer_q + TMR_W'(1);
                if (drain_empty) begin
                    state_d = SWAP;
                end else if (timer_q == TIMEOUT_LAST) begin
                    // Forced swap: the filter never emptied, so the
                    // count is abandoned and the event flagged.
                    state_d = SWAP;
                    err_d   = 1'b1;
                    cnt_d   = '0;
                end
            end
            SWAP: begin
                live_d  = shadow_q;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK or negedge RST_n) begin
        if (!RST_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            timer_q <= '0;
            vin_q   <= 1'b0;
            din_q   <= '0;
            err_q   <= 1'b0;
            for (int i = 0; i < NTAPS; i++) begin
                shadow_q[i] <= '0;
                live_q[i]   <= '0;
            end
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            timer_q  <= timer_d;
            vin_q    <= vin_d;
            din_q    <= din_d;
            err_q    <= err_d;
            shadow_q <= shadow_d;
            live_q   <= live_d;
        end
    end

    assign VIN      = vin_q;
    assign DIN      = din_q;
    assign CFG_BUSY = (state_q != IDLE);
    assign CFG_DONE = (state_q == SWAP);
    assign CFG_ERR  = err_q;

    assign B0  = live_q[0];
    assign B1  = live_q[1];
    assign B2  = live_q[2];
    assign B3  = live_q[3];
    assign B4  = live_q[4];
    assign B5  = live_q[5];
    assign B6  = live_q[6];
    assign B7  = live_q[7];
    assign B8  = live_q[8];
    assign B9  = live_q[9];
    assign B10 = live_q[10];

endmodule

// File: tb/tb_fir_coeff_ctrl.sv
// tb_fir_coeff_ctrl
// Scoreboard bench for fir_coeff_ctrl. Directed stimulus pushes the expected
// forwarded samples and the expected post-swap coefficient banks into queues;
// a monitor pops and compares whenever the DUT presents VIN or CFG_DONE.
module tb_fir_coeff_ctrl;

    typedef logic [10:0][7:0] bank_t;

    logic       CLK;
    logic       RST_n;
    logic       VIN_UP;
    logic [7:0] DIN_UP;
    logic       READY_UP;
    logic       VIN;
    logic [7:0] DIN;
    logic       VOUT_FIR;
    logic       CFG_WE;
    logic [3:0] CFG_ADDR;
    logic [7:0] CFG_DATA;
    logic       CFG_COMMIT;
    logic       CFG_BUSY;
    logic       CFG_DONE;
    logic       CFG_ERR;
    logic [7:0] B0, B1, B2, B3, B4, B5, B6, B7, B8, B9, B10;

    bank_t      b_live;
    bank_t      sh;
    bank_t      bank_q [$];
    logic [7:0] exp_q [$];

    int checks = 0;
    int errors = 0;
    int samples_seen = 0;

    fir_coeff_ctrl dut (
        .CLK        (CLK),
        .RST_n      (RST_n),
        .VIN_UP     (VIN_UP),
        .DIN_UP     (DIN_UP),
        .READY_UP   (READY_UP),
        .VIN        (VIN),
        .DIN        (DIN),
        .VOUT_FIR   (VOUT_FIR),
        .CFG_WE     (CFG_WE),
        .CFG_ADDR   (CFG_ADDR),
        .CFG_DATA   (CFG_DATA),
        .CFG_COMMIT (CFG_COMMIT),
        .CFG_BUSY   (CFG_BUSY),
        .CFG_DONE   (CFG_DONE),
        .CFG_ERR    (CFG_ERR),
        .B0         (B0),
        .B1         (B1),
        .B2         (B2),
        .B3         (B3),
        .B4         (B4),
        .B5         (B5),
        .B6         (B6),
        .B7         (B7),
        .B8         (B8),
        .B9         (B9),
        .B10        (B10)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    always_comb begin
        b_live[0]  = B0;
        b_live[1]  = B1;
        b_live[2]  = B2;
        b_live[3]  = B3;
        b_live[4]  = B4;
        b_live[5]  = B5;
        b_live[6]  = B6;
        b_live[7]  = B7;
        b_live[8]  = B8;
        b_live[9]  = B9;
        b_live[10] = B10;
    end

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s actual=0x%0h expected=0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Drives one cycle of inputs, waits for the edge, then returns inputs to idle.
    task automatic applyStimulus(input logic vin_up, input logic [7:0] din_up,
                                 input logic we, input logic [3:0] addr,
                                 input logic [7:0] data, input logic commit,
                                 input logic vout);
        VIN_UP     = vin_up;
        DIN_UP     = din_up;
        CFG_WE     = we;
        CFG_ADDR   = addr;
        CFG_DATA   = data;
        CFG_COMMIT = commit;
        VOUT_FIR   = vout;
        @(posedge CLK);
        #1;
        VIN_UP     = 1'b0;
        CFG_WE     = 1'b0;
        CFG_COMMIT = 1'b0;
        VOUT_FIR   = 1'b0;
    endtask

    task automatic idleCycle();
        applyStimulus(1'b0, DIN_UP, 1'b0, 4'd0, 8'h00, 1'b0, 1'b0);
    endtask

    task automatic resetDut();
        RST_n = 1'b0;
        @(posedge CLK);
        #1;
        RST_n = 1'b1;
        sh = '0;
    endtask

    // Waits for the swap pulse, then one more cycle so the monitor has
    // compared the new bank before anything else happens.
    task automatic waitDone(input int limit, input string name);
        logic seen;
        seen = 1'b0;
        for (int k = 0; k < limit && !seen; k++) begin
            @(negedge CLK);
            if (CFG_DONE) seen = 1'b1;
            else begin
                @(posedge CLK);
                #1;
            end
        end
        checkOutput(name, {31'd0, seen}, 32'd1);
        @(posedge CLK);
        #1;
        @(negedge CLK);
        #1;
    endtask

    // Scoreboard monitor.
    logic       bank_pending = 1'b0;
    bank_t      bank_exp;
    logic [7:0] din_exp;
    always @(negedge CLK) begin
        if (VIN) begin
            samples_seen++;
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("[TB] FAIL unexpected_sample actual=0x%0h required=none", DIN);
            end else begin
                din_exp = exp_q.pop_front();
                checkOutput("din", {24'd0, DIN}, {24'd0, din_exp});
            end
        end
        if (bank_pending) begin
            bank_pending = 1'b0;
            for (int i = 0; i < 11; i++) begin
                checkOutput($sformatf("B%0d", i), {24'd0, b_live[i]}, {24'd0, bank_exp[i]});
            end
            checkOutput("done_one_cycle", {31'd0, CFG_DONE}, 32'd0);
        end
        if (CFG_DONE) begin
            if (bank_q.size() == 0) begin
                checks++;
                errors++;
                $display("[TB] FAIL unexpected_done actual=1 required=0");
            end else begin
                bank_exp = bank_q.pop_front();
                bank_pending = 1'b1;
            end
        end
    end

    int drain_cycles;
    logic seen_done;

    initial begin
        RST_n = 1'b0; VIN_UP = 1'b0; DIN_UP = 8'h00; VOUT_FIR = 1'b0;
        CFG_WE = 1'b0; CFG_ADDR = 4'd0; CFG_DATA = 8'h00; CFG_COMMIT = 1'b0;
        sh = '0;

        // Reset values.
        #2;
        checkOutput("rst_vin", {31'd0, VIN}, 32'd0);
        checkOutput("rst_din", {24'd0, DIN}, 32'd0);
        checkOutput("rst_busy", {31'd0, CFG_BUSY}, 32'd0);
        checkOutput("rst_done", {31'd0, CFG_DONE}, 32'd0);
        checkOutput("rst_err", {31'd0, CFG_ERR}, 32'd0);
        checkOutput("rst_ready", {31'd0, READY_UP}, 32'd1);
        checkOutput("rst_bank", {31'd0, (b_live == '0)}, 32'd1);
        @(posedge CLK);
        #1;
        RST_n = 1'b1;

        // Stream five samples; each must show up one cycle after acceptance.
        for (int i = 1; i <= 5; i++) begin
            exp_q.push_back(8'(i));
            applyStimulus(1'b1, 8'(i), 1'b0, 4'd0, 8'h00, 1'b0, 1'b0);
            @(negedge CLK);
            checkOutput("vin_latency", {31'd0, VIN}, 32'd1);
        end
        idleCycle();
        @(negedge CLK);
        checkOutput("cnt_after_stream", {28'd0, dut.cnt_q}, 32'd5);

        // Load taps 0x10..0x1A, then commit while the five samples retire.
        for (int i = 0; i < 11; i++) begin
            sh[i] = 8'h10 + 8'(i);
            applyStimulus(1'b0, 8'h00, 1'b1, 4'(i), 8'h10 + 8'(i), 1'b0, 1'b0);
        end
        bank_q.push_back(sh);
        applyStimulus(1'b0, 8'h00, 1'b0, 4'd0, 8'h00, 1'b1, 1'b1);
        for (int k = 0; k < 4; k++) begin
            @(negedge CLK);
            checkOutput("drain_ready_low", {31'd0, READY_UP}, 32'd0);
            checkOutput("drain_busy", {31'd0, CFG_BUSY}, 32'd1);
            applyStimulus(1'b0, 8'h00, 1'b0, 4'd0, 8'h00, 1'b0, 1'b1);
        end
        @(negedge CLK);
        checkOutput("drain_ready_low_empty", {31'd0, READY_UP}, 32'd0);
        checkOutput("no_done_before_empty", {31'd0, CFG_DONE}, 32'd0);
        waitDone(10, "drain_done_seen");
        checkOutput("ready_after_swap", {31'd0, READY_UP}, 32'd1);

        // Empty-filter commit with a same-cycle write to tap 3.
        sh[3] = 8'hA5;
        bank_q.push_back(sh);
        applyStimulus(1'b0, 8'h00, 1'b1, 4'd3, 8'hA5, 1'b1, 1'b0);
        @(negedge CLK);
        checkOutput("fast_busy1", {31'd0, CFG_BUSY}, 32'd1);
        checkOutput("fast_done1", {31'd0, CFG_DONE}, 32'd0);
        @(posedge CLK);
        #1;
        @(negedge CLK);
        checkOutput("fast_busy2", {31'd0, CFG_BUSY}, 32'd1);
        checkOutput("fast_done2", {31'd0, CFG_DONE}, 32'd1);
        @(posedge CLK);
        #1;
        @(negedge CLK);
        checkOutput("fast_busy3", {31'd0, CFG_BUSY}, 32'd0);
        checkOutput("err_clean", {31'd0, CFG_ERR}, 32'd0);

        // Out-of-range address: error, shadow bank untouched.
        applyStimulus(1'b0, 8'h00, 1'b1, 4'd12, 8'h77, 1'b0, 1'b0);
        @(negedge CLK);
        checkOutput("err_bad_addr", {31'd0, CFG_ERR}, 32'd1);
        bank_q.push_back(sh);
        applyStimulus(1'b0, 8'h00, 1'b0, 4'd0, 8'h00, 1'b1, 1'b0);
        waitDone(10, "bad_addr_done_seen");
        checkOutput("cnt_zero_bad_addr", {28'd0, dut.cnt_q}, 32'd0);

        // Write during DRAIN: error, write dropped.
        resetDut();
        sh[2] = 8'h22;
        applyStimulus(1'b0, 8'h00, 1'b1, 4'd2, 8'h22, 1'b0, 1'b0);
        bank_q.push_back(sh);
        applyStimulus(1'b0, 8'h00, 1'b0, 4'd0, 8'h00, 1'b1, 1'b0);
        applyStimulus(1'b0, 8'h00, 1'b1, 4'd5, 8'h55, 1'b0, 1'b0);
        @(negedge CLK);
        checkOutput("err_we_drain", {31'd0, CFG_ERR}, 32'd1);
        checkOutput("done_after_we_drain", {31'd0, CFG_DONE}, 32'd1);
        @(posedge CLK);
        #1;
        @(negedge CLK);
        #1;

        // Retire pulse with nothing in flight.
        resetDut();
        applyStimulus(1'b0, 8'h00, 1'b0, 4'd0, 8'h00, 1'b0, 1'b1);
        @(negedge CLK);
        checkOutput("err_underflow", {31'd0, CFG_ERR}, 32'd1);
        checkOutput("cnt_underflow", {28'd0, dut.cnt_q}, 32'd0);
        checkOutput("ready_underflow", {31'd0, READY_UP}, 32'd1);

        // Saturate the in-flight count, then force a timeout swap.
        resetDut();
        @(negedge CLK);
        checkOutput("err_cleared_by_reset", {31'd0, CFG_ERR}, 32'd0);
        sh[0] = 8'h3C;
        sh[10] = 8'hC3;
        applyStimulus(1'b0, 8'h00, 1'b1, 4'd0, 8'h3C, 1'b0, 1'b0);
        applyStimulus(1'b0, 8'h00, 1'b1, 4'd10, 8'hC3, 1'b0, 1'b0);
        samples_seen = 0;
        for (int k = 0; k < 15; k++) begin
            exp_q.push_back(8'h40 + 8'(k));
            applyStimulus(1'b1, 8'h40 + 8'(k), 1'b0, 4'd0, 8'h00, 1'b0, 1'b0);
        end
        for (int k = 0; k < 5; k++) begin
            applyStimulus(1'b1, 8'hEE, 1'b0, 4'd0, 8'h00, 1'b0, 1'b0);
        end
        @(negedge CLK);
        checkOutput("ready_low_full", {31'd0, READY_UP}, 32'd0);
        checkOutput("samples_accepted", samples_seen, 32'd15);
        bank_q.push_back(sh);
        applyStimulus(1'b0, 8'h00, 1'b0, 4'd0, 8'h00, 1'b1, 1'b0);
        drain_cycles = 0;
        seen_done = 1'b0;
        for (int k = 0; k < 100 && !seen_done; k++) begin
            @(negedge CLK);
            if (CFG_DONE) seen_done = 1'b1;
            else begin
                if (CFG_BUSY) drain_cycles++;
                @(posedge CLK);
                #1;
            end
        end
        checkOutput("timeout_done_seen", {31'd0, seen_done}, 32'd1);
        checkOutput("drain_cycles", drain_cycles, 32'd64);
        @(posedge CLK);
        #1;
        @(negedge CLK);
        checkOutput("err_timeout", {31'd0, CFG_ERR}, 32'd1);
        checkOutput("cnt_timeout", {28'd0, dut.cnt_q}, 32'd0);
        checkOutput("ready_after_timeout", {31'd0, READY_UP}, 32'd1);

        // Asynchronous reset in the middle of a drain.
        exp_q.push_back(8'h61);
        applyStimulus(1'b1, 8'h61, 1'b0, 4'd0, 8'h00, 1'b0, 1'b0);
        exp_q.push_back(8'h62);
        applyStimulus(1'b1, 8'h62, 1'b0, 4'd0, 8'h00, 1'b0, 1'b0);
        idleCycle();
        idleCycle();
        applyStimulus(1'b0, 8'h00, 1'b0, 4'd0, 8'h00, 1'b1, 1'b0);
        idleCycle();
        @(negedge CLK);
        checkOutput("busy_before_reset", {31'd0, CFG_BUSY}, 32'd1);
        checkOutput("bank_before_reset", {24'd0, B0}, 32'h3C);
        #1;
        RST_n = 1'b0;
        #1;
        checkOutput("async_busy", {31'd0, CFG_BUSY}, 32'd0);
        checkOutput("async_ready", {31'd0, READY_UP}, 32'd1);
        checkOutput("async_vin", {31'd0, VIN}, 32'd0);
        checkOutput("async_err", {31'd0, CFG_ERR}, 32'd0);
        for (int i = 0; i < 11; i++) begin
            checkOutput($sformatf("async_B%0d", i), {24'd0, b_live[i]}, 32'd0);
        end
        @(posedge CLK);
        #1;
        RST_n = 1'b1;
        repeat (2) @(posedge CLK);
        #1;

        checkOutput("sample_queue_empty", exp_q.size(), 32'd0);
        checkOutput("bank_queue_empty", bank_q.size(), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/fir_coeff_ctrl.md
# fir_coeff_ctrl

Coefficient-bank and input-sequencing controller for the 11-tap, 8-bit `myfir` filter. It holds a shadow coefficient bank written over a simple register port and forwards the upstream sample stream into the filter. It counts samples in flight through the filter. On a commit request it stalls the upstream source, drains the filter, and swaps the shadow bank into the live B0..B10 outputs in a single cycle, so no output sample is ever computed with a mix of old and new taps.

## Interface
Parameters:
- `NB`, 8, sample/coefficient width
- `MAX_INFLIGHT`, 15, in-flight sample limit; upstream is stalled at this count
- `CNT_W`, 4, in-flight counter width (must hold `MAX_INFLIGHT`)
- `DRAIN_TIMEOUT`, 64, maximum cycles spent in DRAIN before a forced swap

Ports:
- `CLK`  in  1  clock; all logic on the rising edge
- `RST_n`  in  1  reset; asynchronous, active-low
- `VIN_UP`  in  1  upstream sample valid
- `DIN_UP`  in  NB  upstream sample
- `READY_UP`  out  1  upstream may present a sample; when low, upstream holds VIN_UP/DIN_UP
- `VIN`  out  1  valid to FIR
- `DIN`  out  NB  sample to FIR
- `VOUT_FIR`  in  1  FIR output valid; one pulse per retired sample
- `CFG_WE`  in  1  shadow-bank write strobe
- `CFG_ADDR`  in  4  tap index, 0..10
- `CFG_DATA`  in  NB  coefficient value
- `CFG_COMMIT`  in  1  request a bank swap
- `CFG_BUSY`  out  1  high in DRAIN and SWAP
- `CFG_DONE`  out  1  one-cycle pulse when the swap completes
- `CFG_ERR`  out  1  sticky error flag; cleared only by reset
- `B0`..`B10`  out  NB each  live coefficients to FIR

## Operation
FSM states are IDLE, DRAIN and SWAP. The reset state is IDLE.

- IDLE
  - `READY_UP` = (cnt < `MAX_INFLIGHT`). This is combinational from the state and counter.
  - Accept = `VIN_UP` & `READY_UP`.
  - `CFG_COMMIT` moves the FSM to DRAIN.
- DRAIN
  - `READY_UP` = 0.
  - Exit to SWAP when cnt == 0 and `VIN` == 0.
  - Exit to SWAP on the timeout condition below.
- SWAP (one cycle)
  - Live bank ← shadow bank.
  - `CFG_DONE` = 1.
  - Next state is IDLE.
- Forwarding: `VIN` ← accept. `DIN` ← `DIN_UP` on accept; otherwise `DIN` holds its value.
- In-flight counter cnt (`CNT_W` bits):
  - Increments when `VIN` = 1.
  - Decrements when `VOUT_FIR` = 1.
  - Both in the same cycle: cnt is unchanged.
  - `VOUT_FIR` with cnt == 0 and no increment: cnt stays 0 and `CFG_ERR` is set.
- Shadow writes:
  - Accepted only in IDLE, and only for `CFG_ADDR` ≤ 10.
  - Addresses 11..15 are ignored and set `CFG_ERR`.
  - `CFG_WE` in DRAIN or SWAP is ignored and sets `CFG_ERR`.
  - A write in the same cycle as `CFG_COMMIT` is applied and is included in the swap.
- `CFG_COMMIT` in DRAIN or SWAP is ignored; it sets no error.
- Drain timeout:
  - A timer counts cycles in DRAIN.
  - On reaching `DRAIN_TIMEOUT` with cnt ≠ 0: go to SWAP, set `CFG_ERR`, clear cnt to 0.
- `CFG_BUSY` = (state ≠ IDLE), registered with the state.
- Reset mid-operation: all state is lost immediately.
  - FSM returns to IDLE and cnt and the timer are cleared.
  - Shadow and live banks are cleared to 0.

## Timing
- Reset values:
  - `VIN` = 0, `DIN` = 0, `B0`..`B10` = 0.
  - `CFG_BUSY` = 0, `CFG_DONE` = 0, `CFG_ERR` = 0.
  - `READY_UP` = 1, since the FSM is in IDLE with cnt = 0.
- Sample path latency: an accepted sample appears on `VIN`/`DIN` one cycle after the accept edge.
- A sample presented in the same cycle as `CFG_COMMIT` is accepted, because the FSM is still IDLE. `READY_UP` falls the following cycle.
- Drain:
  - Minimum commit-to-DONE time is 2 cycles: one in DRAIN, one in SWAP, when cnt = 0 and `VIN` = 0.
  - New `B` values are visible the cycle after SWAP, the same edge on which `CFG_DONE` falls.
  - `READY_UP` returns to 1 in that same cycle.
- A bank swap never happens while cnt > 0, except on the timeout path.

## Test plan
- Reset with `RST_n` = 0 → all outputs at their reset values, `READY_UP` = 1. Release reset and stream 5 samples (0x01..0x05) → they appear on `VIN`/`DIN` 1 cycle later, unchanged; cnt = 5.
- Write taps 0..10 = 0x10..0x1A, then `CFG_COMMIT` while `VOUT_FIR` retires the 5 samples over 5 cycles → `READY_UP` = 0 through the drain. `CFG_DONE` pulses exactly once after cnt reaches 0, and `B0` = 0x10 … `B10` = 0x1A the next cycle.
- Commit with the filter empty → `CFG_BUSY` high for exactly 2 cycles, `CFG_DONE` in the 2nd cycle; a `CFG_WE` at addr 3 in the commit cycle is reflected in `B3`.
- `CFG_WE` at addr 12, `CFG_WE` during DRAIN, and `VOUT_FIR` with cnt = 0 → each sets `CFG_ERR`; the shadow bank and cnt are unchanged.
- Hold `VIN_UP` = 1 with no `VOUT_FIR` → exactly 15 samples accepted, then `READY_UP` = 0. Commit → forced swap after 64 DRAIN cycles, `CFG_ERR` = 1, cnt = 0.
- Assert `RST_n` during DRAIN → `CFG_BUSY` = 0, all `B` outputs = 0, `READY_UP` = 1 without waiting for a clock edge.
